// File: rtl/full_adder_1bit_structural_pkg.sv
// Shared constants for the 1-bit structural full adder and anything built from it.
package full_adder_1bit_structural_pkg;

  // Cycles from an in_valid capture to out_valid when REG_OUT=1.
  localparam int unsigned FA_LATENCY = 1;

endpackage

// File: rtl/full_adder_1bit_structural_half_adder.sv
// Gate-level half adder: s = a^b, c = a&b.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  xor u_xor (s, a, b);
  and u_and (c, a, b);

endmodule

// File: rtl/full_adder_1bit_structural.sv
// 1-bit full adder from two half adders plus an OR, with an optional
// registered copy of sum/carry qualified by a valid flag.
module full_adder_1bit_structural
  import full_adder_1bit_structural_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic in_valid,
  output logic sum_comb,
  output logic cout_comb,
  output logic sum,
  output logic cout,
  output logic out_valid
);

  logic p;
  logic g1;
  logic g2;

  half_adder u_ha1 (
    .a (a),
    .b (b),
    .s (p),
    .c (g1)
  );

  half_adder u_ha2 (
    .a (p),
    .b (cin),
    .s (sum_comb),
    .c (g2)
  );

  or u_or_carry (cout_comb, g1, g2);

  generate
    if (REG_OUT) begin : g_reg
      logic sum_q,   sum_d;
      logic cout_q,  cout_d;
      logic valid_q, valid_d;

      // Inputs are only looked at when in_valid is high, so an unknown
      // a/b/cin on an idle cycle never reaches the held result.
      always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = 1'b0;
        if (in_valid) begin
          sum_d   = sum_comb;
          cout_d  = cout_comb;
          valid_d = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sum_q   <= 1'b0;
          cout_q  <= 1'b0;
          valid_q <= 1'b0;
        end else begin
          sum_q   <= sum_d;
          cout_q  <= cout_d;
          valid_q <= valid_d;
        end
      end

      assign sum       = sum_q;
      assign cout      = cout_q;
      assign out_valid = valid_q;
    end else begin : g_comb
      logic unused_clk_rst;

      assign unused_clk_rst = clk ^ rst_n;
      assign sum            = sum_comb;
      assign cout           = cout_comb;
      assign out_valid      = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder_1bit_structural.sv
// Self-checking bench for full_adder_1bit_structural (registered and pass-through builds).
module tb_full_adder_1bit_structural;

  logic clk;
  logic rst_n;
  logic a, b, cin, in_valid;

  logic sum_comb, cout_comb, sum, cout, out_valid;
  logic sum_comb0, cout_comb0, sum0, cout0, out_valid0;

  int unsigned checks;
  int unsigned errors;

  // Reference state for the registered build.
  logic m_sum, m_cout, m_valid;

  full_adder_1bit_structural #(.REG_OUT(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum_comb  (sum_comb),
    .cout_comb (cout_comb),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  full_adder_1bit_structural #(.REG_OUT(1'b0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum_comb  (sum_comb0),
    .cout_comb (cout_comb0),
    .sum       (sum0),
    .cout      (cout0),
    .out_valid (out_valid0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check the combinational paths, clock, check the registers.
  task automatic cyc(input string tag, input logic ai, input logic bi, input logic ci,
                     input logic vi, input logic ri);
    int unsigned total;
    a = ai; b = bi; cin = ci; in_valid = vi; rst_n = ri;
    #1;
    total = int'(ai) + int'(bi) + int'(ci);
    chk({tag, ".sum_comb"},  sum_comb,  total[0]);
    chk({tag, ".cout_comb"}, cout_comb, total[1]);
    chk({tag, ".r0.sum"},    sum0,      total[0]);
    chk({tag, ".r0.cout"},   cout0,     total[1]);
    chk({tag, ".r0.valid"},  out_valid0, vi);
    if (!ri) begin
      m_sum = 1'b0; m_cout = 1'b0; m_valid = 1'b0;
    end else if (vi) begin
      m_sum = total[0]; m_cout = total[1]; m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, ".sum"},       sum,       m_sum);
    chk({tag, ".cout"},      cout,      m_cout);
    chk({tag, ".out_valid"}, out_valid, m_valid);
  endtask

  initial begin
    checks = 0; errors = 0;
    m_sum = 1'b0; m_cout = 1'b0; m_valid = 1'b0;
    rst_n = 1'b0; in_valid = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;

    // Reset beats in_valid.
    cyc("rst0", 1, 1, 1, 1, 0);
    cyc("rst1", 1, 1, 1, 1, 0);

    // Directed vectors.
    cyc("d000", 0, 0, 0, 1, 1);
    cyc("d111", 1, 1, 1, 1, 1);
    cyc("d110", 1, 1, 0, 1, 1);
    cyc("d001", 0, 0, 1, 1, 1);

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      cyc($sformatf("sweep%0d", i), v[2], v[1], v[0], 1, 1);
    end

    // Hold on idle cycle.
    cyc("hold_cap", 1, 1, 0, 1, 1);
    cyc("hold_idle", 0, 0, 1, 0, 1);

    // Mid-stream reset discards the pending result.
    cyc("mid_a", 1, 0, 1, 1, 1);
    cyc("mid_rst", 1, 1, 1, 1, 0);
    cyc("mid_rel", 0, 1, 1, 1, 1);

    // Pass-through build: output follows input with no clock edge.
    a = 1'b1; b = 1'b0; cin = 1'b0; in_valid = 1'b1; rst_n = 1'b1;
    #1;
    chk("r0_100.sum",   sum0,       1'b1);
    chk("r0_100.cout",  cout0,      1'b0);
    chk("r0_100.valid", out_valid0, 1'b1);
    in_valid = 1'b0;
    #1;
    chk("r0_idle.valid", out_valid0, 1'b0);
    @(posedge clk);
    #1;

    // Randomized traffic with occasional resets and idle cycles.
    for (int i = 0; i < 60; i++) begin
      logic [4:0] r;
      r = 5'($urandom);
      cyc($sformatf("rnd%0d", i), r[0], r[1], r[2], r[3] | r[4],
          ($urandom_range(0, 15) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/full_adder_1bit_structural.md
Name: full_adder_1bit_structural

Overview:
- 1-bit full adder built structurally from gate primitives: two half adders plus an OR for the carry.
- Produces a combinational sum/carry and a registered copy with a valid flag.
- Leaf arithmetic cell, instantiated by ripple-carry adders and small datapath/ALU slices.
- Clocking: one clock; reset is synchronous and active-low. Ports are clk and rst_n.

Parameters:
- REG_OUT, default 1: 1 = registered outputs with 1-cycle latency; 0 = registered outputs equal the combinational path and out_valid = in_valid.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- a  input  1  addend bit A.
- b  input  1  addend bit B.
- cin  input  1  carry in.
- in_valid  input  1  qualifies a/b/cin for capture.
- sum_comb  output  1  combinational a^b^cin.
- cout_comb  output  1  combinational (a&b)|(cin&(a^b)).
- sum  output  1  registered sum.
- cout  output  1  registered carry out.
- out_valid  output  1  sum/cout hold a freshly computed result.

Behaviour:
- Structure:
  - Half adder 1: p = a^b, g1 = a&b.
  - Half adder 2: sum_comb = p^cin, g2 = p&cin.
  - cout_comb = g1|g2.
  - Gate-level instantiation only; no behavioural '+' operator.
- Combinational outputs:
  - Pure functions of a/b/cin.
  - Independent of clk, rst_n and in_valid.
  - Valid in the same delta as an input change.
- Truth table (a b cin -> sum cout):
  - 000->0 0, 001->1 0, 010->1 0, 011->0 1
  - 100->1 0, 101->0 1, 110->0 1, 111->1 1
  - Equivalently {cout,sum} = a+b+cin.
- Reset:
  - On the rising clk edge with rst_n=0: sum=0, cout=0, out_valid=0.
  - Reset has priority over in_valid.
  - Asserting reset mid-stream discards any pending result.
- Capture (REG_OUT=1):
  - At an edge with rst_n=1 and in_valid=1: sum<=sum_comb, cout<=cout_comb, out_valid<=1.
  - At an edge with in_valid=0: sum/cout hold their last value, out_valid<=0.
  - Latency exactly 1 cycle.
  - Back-to-back in_valid gives one result per cycle; there is no backpressure.
- REG_OUT=0: sum=sum_comb, cout=cout_comb, out_valid=in_valid, all combinational. Reset affects nothing.
- X handling: inputs are sampled only when in_valid=1; X on a/b/cin while in_valid=0 must not reach sum/cout.

Decomposition:
- No shared package typedefs are needed.
- Optional package constant FA_LATENCY = 1 for benches and ripple builders.
- One natural sub-module: half_adder (ports a, b, s, c; s=a^b, c=a&b), instantiated twice.
- The OR gate and output register live in the top.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1, a=b=cin=1 -> sum=0, cout=0, out_valid=0 after each edge.
- Directed vectors, in_valid=1 each cycle, one cycle later:
  - a=0,b=0,cin=0 -> sum=0, cout=0
  - a=1,b=1,cin=1 -> sum=1, cout=1
  - a=1,b=1,cin=0 -> sum=0, cout=1
  - a=0,b=0,cin=1 -> sum=1, cout=0
  - out_valid=1 throughout.
- Exhaustive sweep: all 8 combinations back-to-back. Check sum_comb/cout_comb in the same cycle and sum/cout the next cycle against a+b+cin; out_valid stays 1.
- Hold: capture 1,1,0 (sum=0, cout=1), then in_valid=0 with a=0,b=0,cin=1 -> sum=0, cout=1 held, out_valid=0, while sum_comb=1, cout_comb=0.
- Mid-stream reset: stream 1,0,1, then assert rst_n=0 for one edge while in_valid=1 -> sum=0, cout=0, out_valid=0. Release with 0,1,1 -> next edge sum=0, cout=1, out_valid=1.
- REG_OUT=0 build: apply 1,0,0 -> sum=1, cout=0 with no clock edge; out_valid follows in_valid combinationally.
